// File: rtl/cla_add_arbiter.sv
// -----------------------------------------------------------------------------
// cla_add_arbiter
//   Shares one 16-bit carry-lookahead adder between NREQ requesters. A
//   round-robin arbiter grants at most one request per cycle. The granted
//   operand pair is muxed into the adder, and the sum is registered together
//   with the winner's index. That output register is the only storage.
//   A new request is accepted in the same cycle the previous result is
//   consumed, so with res_ready held high the block delivers one sum per cycle.
//
// Ports
//   clk        in   1        rising-edge clock
//   nrst       in   1        asynchronous active-low reset
//   req_valid  in   NREQ     requester i holds a valid operand pair
//   req_ready  out  NREQ     one-hot grant; handshake fires on valid & ready
//   req_a      in   NREQ*W   operand A, requester i at [i*W +: W]
//   req_b      in   NREQ*W   operand B, requester i at [i*W +: W]
//   res_valid  out  1        res_sum/res_id hold an undelivered result
//   res_ready  in   1        consumer accepts the result this cycle
//   res_sum    out  W        (a + b) mod 2^16 of the granted request
//   res_id     out  IDW      index of the requester that produced res_sum
//
// Parameters
//   NREQ  number of requesters, 2..8
//   W     operand width; the adder is fixed at 16 bits
// -----------------------------------------------------------------------------

// Two-level 16-bit carry-lookahead adder: 4-bit groups with local lookahead,
// plus a group-level lookahead unit that produces the group carry-ins.
// The carry-out is not needed, so bit 15's generate term is never formed.
module cla16_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] prop;
  logic [14:0] gen;
  logic [2:0]  grp_g;
  logic [2:0]  grp_p;
  logic [3:0]  grp_c;
  logic [15:0] carry;

  assign prop = a ^ b;
  assign gen  = a[14:0] & b[14:0];

  // Group generate/propagate for the three lower groups; group 3 only
  // feeds the dropped carry-out.
  for (genvar j = 0; j < 3; j++) begin : g_grp_gp
    assign grp_g[j] = gen[4*j+3]
                    | (prop[4*j+3] & gen[4*j+2])
                    | (prop[4*j+3] & prop[4*j+2] & gen[4*j+1])
                    | (prop[4*j+3] & prop[4*j+2] & prop[4*j+1] & gen[4*j]);
    assign grp_p[j] = &prop[4*j +: 4];
  end

  // Group carry-ins, all computed in parallel from cin.
  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);

  // Bit carries inside each group, flattened rather than rippled.
  for (genvar j = 0; j < 4; j++) begin : g_local
    assign carry[4*j]   = grp_c[j];
    assign carry[4*j+1] = gen[4*j] | (prop[4*j] & grp_c[j]);
    assign carry[4*j+2] = gen[4*j+1] | (prop[4*j+1] & gen[4*j])
                        | (prop[4*j+1] & prop[4*j] & grp_c[j]);
    assign carry[4*j+3] = gen[4*j+2] | (prop[4*j+2] & gen[4*j+1])
                        | (prop[4*j+2] & prop[4*j+1] & gen[4*j])
                        | (prop[4*j+2] & prop[4*j+1] & prop[4*j] & grp_c[j]);
  end

  assign sum = prop ^ carry;

endmodule

module cla_add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [W-1:0]            res_sum,
  output logic [$clog2(NREQ)-1:0] res_id
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IDW-1:0]  id_q, id_d;

  logic            can_accept;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] grant_vec;
  logic [W-1:0]    adder_a, adder_b, adder_sum;

  // A result leaving this cycle frees the register for a new one.
  assign can_accept = (state_q == EMPTY) || res_ready;

  // Round-robin scan starting at ptr. The index is formed one bit wider so
  // the wrap also works when NREQ is not a power of two.
  always_comb begin
    logic [IDW:0]   scan;
    logic [IDW-1:0] idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    scan      = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) begin
        scan = scan - (IDW+1)'(NREQ);
      end
      idx = scan[IDW-1:0];
      if (can_accept && !grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_vld) begin
      grant_vec[grant_id] = 1'b1;
    end
  end

  // No grant may be visible while reset is asserted.
  assign req_ready = nrst ? grant_vec : '0;

  // Operand mux into the shared adder, using constant slices only.
  always_comb begin
    adder_a = '0;
    adder_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        adder_a = req_a[k*W +: W];
        adder_b = req_b[k*W +: W];
      end
    end
  end

  cla16_adder u_adder (
    .a   (adder_a),
    .b   (adder_b),
    .cin (1'b0),
    .sum (adder_sum)
  );

  // A grant always implies a fire, because a bit is only granted when its
  // valid is set. Without a fire, a consumed result empties the register
  // and the stale sum/id are kept.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    id_d    = id_q;
    if (grant_vld) begin
      state_d = FULL;
      sum_d   = adder_sum;
      id_d    = grant_id;
      ptr_d   = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
    end else if (state_q == FULL && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cla_add_arbiter
//   Directed bench for the shared CLA adder arbiter with NREQ=4. Expected
//   values are hand-computed constants. A closing random phase compares
//   against a small arbiter/adder model that is kept inside the bench.
// -----------------------------------------------------------------------------
module tb_cla_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk;
  logic              nrst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic [1:0]        res_id;

  int compareCount;
  int mismatchCount;

  // Sums for requester i when a_i = i*16'h1111 and b_i = 16'h0001.
  logic [15:0] fairSum [4] = '{16'h0001, 16'h1112, 16'h2223, 16'h3334};
  logic [1:0]  fairIds [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3};

  // Random-phase model state.
  logic [3:0]  pend;
  logic [15:0] opA [4];
  logic [15:0] opB [4];
  logic        mValid;
  logic [15:0] mSum;
  logic [1:0]  mId;
  logic [1:0]  mPtr;
  logic [3:0]  expReady;
  int          gnt;
  int          scanIdx;

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cla_add_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
  );

  // Every comparison in the bench is counted and reported here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Checks the whole result port in one go.
  task automatic checkResult(input string tag, input logic expValid,
                             input logic [15:0] expSum, input logic [1:0] expId);
    checkOutput({tag, "_valid"}, {31'd0, res_valid}, {31'd0, expValid});
    checkOutput({tag, "_sum"}, {16'd0, res_sum}, {16'd0, expSum});
    checkOutput({tag, "_id"}, {30'd0, res_id}, {30'd0, expId});
  endtask

  // Drives the request valids and the consumer's ready.
  task automatic applyStimulus(input logic [3:0] valid, input logic rready);
    req_valid = valid;
    res_ready = rready;
  endtask

  // Loads one requester's operand pair.
  task automatic setOperands(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
  endtask

  // Advances to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main directed sequence followed by the random model comparison.
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    req_a = '0;
    req_b = '0;
    nrst  = 1'b0;
    applyStimulus(4'b1111, 1'b0);

    // Reset held across an edge with every requester asking.
    tick();
    checkOutput("rst_ready", {28'd0, req_ready}, 32'h0);
    checkResult("rst", 1'b0, 16'h0000, 2'd0);

    nrst = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    #1;
    checkOutput("rst_first_grant", {28'd0, req_ready}, 32'h1);

    // Single request from requester 0.
    setOperands(0, 16'h1234, 16'h0FFF);
    applyStimulus(4'b0001, 1'b1);
    #1;
    checkOutput("single_ready", {28'd0, req_ready}, 32'h1);
    tick();
    checkResult("single", 1'b1, 16'h2233, 2'd0);

    // Wrap-around sums. The pointer has moved past 0, so requesters 1, 2 and 3
    // are used in turn.
    setOperands(1, 16'hFFFF, 16'h0001);
    applyStimulus(4'b0010, 1'b1);
    #1;
    checkOutput("wrap1_ready", {28'd0, req_ready}, 32'h2);
    tick();
    checkResult("wrap1", 1'b1, 16'h0000, 2'd1);

    setOperands(2, 16'h8000, 16'h8000);
    applyStimulus(4'b0100, 1'b1);
    #1;
    checkOutput("wrap2_ready", {28'd0, req_ready}, 32'h4);
    tick();
    checkResult("wrap2", 1'b1, 16'h0000, 2'd2);

    setOperands(3, 16'hAAAA, 16'h5555);
    applyStimulus(4'b1000, 1'b1);
    #1;
    checkOutput("wrap3_ready", {28'd0, req_ready}, 32'h8);
    tick();
    checkResult("wrap3", 1'b1, 16'hFFFF, 2'd3);

    // Fairness: all four requesters asking. Then only 1 and 3 ask,
    // starting from pointer 2.
    for (int i = 0; i < 4; i++) begin
      setOperands(i, 16'(i * 16'h1111), 16'h0001);
    end
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 9; k++) begin
      if (k == 6) begin
        applyStimulus(4'b1010, 1'b1);
      end
      tick();
      checkResult("fair", 1'b1, fairSum[fairIds[k]], fairIds[k]);
    end

    // Backpressure: the result from id 3 must hold and no grant may appear.
    applyStimulus(4'b1010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("bp_ready", {28'd0, req_ready}, 32'h0);
      checkResult("bp_hold", 1'b1, 16'h3334, 2'd3);
      tick();
    end
    applyStimulus(4'b1010, 1'b1);
    #1;
    checkOutput("bp_release_ready", {28'd0, req_ready}, 32'h2);
    tick();
    checkResult("bp_new", 1'b1, 16'h1112, 2'd1);

    // Reset pulse between edges while full and stalled. Before the pulse the
    // pointer is 2, so a grant to 0 afterwards shows that the pointer was cleared.
    applyStimulus(4'b1111, 1'b0);
    #1;
    nrst = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    #1;
    checkResult("midrst", 1'b0, 16'h0000, 2'd0);
    checkOutput("midrst_ready", {28'd0, req_ready}, 32'h0);
    nrst = 1'b1;
    #1;
    checkOutput("midrst_ptr", {28'd0, req_ready}, 32'h1);
    applyStimulus(4'b0000, 1'b1);
    tick();

    // Random traffic against the bench's own arbiter/adder model.
    pend   = 4'b0000;
    mValid = 1'b0;
    mSum   = 16'h0000;
    mId    = 2'd0;
    mPtr   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      opA[i] = 16'h0000;
      opB[i] = 16'h0000;
    end
    for (int c = 0; c < 10000; c++) begin
      checkOutput("rnd_valid", {31'd0, res_valid}, {31'd0, mValid});
      if (mValid) begin
        checkOutput("rnd_sum", {16'd0, res_sum}, {16'd0, mSum});
        checkOutput("rnd_id", {30'd0, res_id}, {30'd0, mId});
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          opA[i]  = 16'($urandom);
          opB[i]  = 16'($urandom);
          setOperands(i, opA[i], opB[i]);
        end
      end
      applyStimulus(pend, ($urandom_range(0, 3) != 0));
      #1;
      gnt = -1;
      if (!mValid || res_ready) begin
        for (int k = 0; k < 4; k++) begin
          scanIdx = (int'(mPtr) + k) % 4;
          if (gnt < 0 && pend[scanIdx]) begin
            gnt = scanIdx;
          end
        end
      end
      expReady = (gnt >= 0) ? (4'b0001 << gnt) : 4'b0000;
      checkOutput("rnd_ready", {28'd0, req_ready}, {28'd0, expReady});
      tick();
      if (gnt >= 0) begin
        mValid    = 1'b1;
        mSum      = opA[gnt] + opB[gnt];
        mId       = 2'(gnt);
        mPtr      = 2'((gnt + 1) % 4);
        pend[gnt] = 1'b0;
      end else if (mValid && res_ready) begin
        mValid = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
